// File: rtl/pcs_tx_pkg.sv
// Purpose: shared constants and state type for the 1000BASE-X PCS transmit path.
//   K-code octets for the ordered sets and the transmit ordered-set state enum.
package pcs_tx_pkg;

  localparam int unsigned OCT_W = 8;

  localparam logic [OCT_W-1:0] K28_5   = 8'hBC; // comma, first octet of /I/
  localparam logic [OCT_W-1:0] K27_7_S = 8'hFB; // /S/ start of packet
  localparam logic [OCT_W-1:0] K29_7_T = 8'hFD; // /T/ end of packet
  localparam logic [OCT_W-1:0] K23_7_R = 8'hF7; // /R/ carrier extend / alignment
  localparam logic [OCT_W-1:0] K30_7_V = 8'hFE; // /V/ error propagation

  // Each state names the code group most recently emitted.
  typedef enum logic [3:0] {
    IDLE_K,
    IDLE_D,
    SOP,
    DATA,
    ERR,
    EOP_T,
    EXT,
    R1,
    R2
  } state_e;

endpackage

// File: rtl/pcs_sat_counter.sv
// Purpose: saturating up-counter with synchronous clear taking priority.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_inc       count one event this cycle
//   i_clr       synchronous clear, wins over i_inc
//   o_cnt       counter value, holds at all-ones
module pcs_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear first, then increment unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pcs_tx_oset_gen.sv
// Purpose: 1000BASE-X PCS transmit ordered-set generator. Converts GMII
//   TXD/TX_EN/TX_ER into one code group per GTX_CLK for the 8b/10b encoder,
//   inserting /I/ /S/ /T/ /R/ /V/, keeping even/odd alignment and counting
//   packets and errors.
// Ports:
//   GTX_CLK, mr_main_reset    clock, asynchronous active-low reset
//   TXD, TX_EN, TX_ER         GMII transmit inputs
//   cnt_clr                   synchronous clear of both statistics counters
//   tx_byte, tx_is_k          code group octet and K flag to the encoder
//   tx_even                   current code group sits at an even position
//   transmitting              high while /S/, data, /V/ or /T/ is emitted
//   pkt_cnt, err_cnt          saturating /S/ and /V/ counts
module pcs_tx_oset_gen #(
  parameter logic [7:0]  IDLE_D   = 8'h50,
  parameter bit          EXT_EN   = 1'b1,
  parameter bit          ERR_PROP = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic [7:0]       TXD,
  input  logic             TX_EN,
  input  logic             TX_ER,
  input  logic             cnt_clr,
  output logic [7:0]       tx_byte,
  output logic             tx_is_k,
  output logic             tx_even,
  output logic             transmitting,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  import pcs_tx_pkg::*;

  state_e     r_state;
  state_e     w_nxt;
  logic [7:0] r_tx_byte;
  logic       r_tx_is_k;
  logic       r_tx_even;
  logic       r_transmitting;
  logic [7:0] w_byte;
  logic       w_is_k;
  logic       w_tx;
  logic       w_pkt_inc;
  logic       w_err_inc;

  // Next code group from the last emitted one, and its octet/flags.
  always_comb begin
    w_nxt  = r_state;
    w_byte = K28_5;
    w_is_k = 1'b1;
    w_tx   = 1'b0;

    case (r_state)
      IDLE_K:              w_nxt = pcs_tx_pkg::IDLE_D;
      pcs_tx_pkg::IDLE_D:  w_nxt = TX_EN ? SOP : IDLE_K;
      SOP, DATA, ERR: begin
        if (TX_EN) begin
          w_nxt = (TX_ER && ERR_PROP) ? ERR : DATA;
        end else begin
          w_nxt = EOP_T;
        end
      end
      EOP_T:               w_nxt = (TX_ER && EXT_EN) ? EXT : R1;
      EXT:                 w_nxt = (TX_ER && !TX_EN && EXT_EN) ? EXT : R1;
      // R1 occupies the current position; a second /R/ is needed when the
      // following position would be odd so that /I/ starts even.
      R1:                  w_nxt = r_tx_even ? R2 : IDLE_K;
      R2:                  w_nxt = IDLE_K;
      default:             w_nxt = IDLE_K;
    endcase

    case (w_nxt)
      IDLE_K: begin
        w_byte = K28_5;
      end
      pcs_tx_pkg::IDLE_D: begin
        w_byte = IDLE_D;
        w_is_k = 1'b0;
      end
      SOP: begin
        w_byte = K27_7_S;
        w_tx   = 1'b1;
      end
      DATA: begin
        w_byte = TXD;
        w_is_k = 1'b0;
        w_tx   = 1'b1;
      end
      ERR: begin
        w_byte = K30_7_V;
        w_tx   = 1'b1;
      end
      EOP_T: begin
        w_byte = K29_7_T;
        w_tx   = 1'b1;
      end
      EXT, R1, R2: begin
        w_byte = K23_7_R;
      end
      default: begin
        w_byte = K28_5;
      end
    endcase
  end

  // State and output registers; reset state reads as an even comma.
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      r_state        <= IDLE_K;
      r_tx_byte      <= K28_5;
      r_tx_is_k      <= 1'b1;
      r_tx_even      <= 1'b1;
      r_transmitting <= 1'b0;
    end else begin
      r_state        <= w_nxt;
      r_tx_byte      <= w_byte;
      r_tx_is_k      <= w_is_k;
      r_tx_even      <= ~r_tx_even;
      r_transmitting <= w_tx;
    end
  end

  assign w_pkt_inc = (w_nxt == SOP);
  assign w_err_inc = (w_nxt == ERR);

  pcs_sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clk   (GTX_CLK),
    .rst_n (mr_main_reset),
    .i_inc (w_pkt_inc),
    .i_clr (cnt_clr),
    .o_cnt (pkt_cnt)
  );

  pcs_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (GTX_CLK),
    .rst_n (mr_main_reset),
    .i_inc (w_err_inc),
    .i_clr (cnt_clr),
    .o_cnt (err_cnt)
  );

  assign tx_byte      = r_tx_byte;
  assign tx_is_k      = r_tx_is_k;
  assign tx_even      = r_tx_even;
  assign transmitting = r_transmitting;

endmodule

// File: tb/tb_pcs_tx_oset_gen.sv
// Bench for pcs_tx_oset_gen: two instances (default parameters, and
// IDLE_D=C5/EXT_EN=0/ERR_PROP=0/CNT_W=2) share one GMII stimulus stream and
// are each compared every cycle against a phase-based reference model.
module tb_pcs_tx_oset_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic       cnt_clr;

  logic [7:0]  o_b [2];
  logic        o_k [2];
  logic        o_e [2];
  logic        o_t [2];
  logic [15:0] pc0, ec0;
  logic [1:0]  pc1, ec1;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: phase 0 idle, 1 packet, 2 tail.
  int         m_phase [2];
  bit         m_comma [2];  // last idle group was the comma
  bit         m_r1    [2];  // the closing /R/ has been emitted
  bit         m_first [2];  // last group was /T/
  int         m_pkt   [2];
  int         m_err   [2];
  logic [7:0] e_byte  [2];
  bit         e_k     [2];
  bit         e_even  [2];
  bit         e_tx    [2];
  int         n_pos;

  pcs_tx_oset_gen u_dut0 (
    .GTX_CLK       (clk),
    .mr_main_reset (rst_n),
    .TXD           (TXD),
    .TX_EN         (TX_EN),
    .TX_ER         (TX_ER),
    .cnt_clr       (cnt_clr),
    .tx_byte       (o_b[0]),
    .tx_is_k       (o_k[0]),
    .tx_even       (o_e[0]),
    .transmitting  (o_t[0]),
    .pkt_cnt       (pc0),
    .err_cnt       (ec0)
  );

  pcs_tx_oset_gen #(
    .IDLE_D   (8'hC5),
    .EXT_EN   (1'b0),
    .ERR_PROP (1'b0),
    .CNT_W    (2)
  ) u_dut1 (
    .GTX_CLK       (clk),
    .mr_main_reset (rst_n),
    .TXD           (TXD),
    .TX_EN         (TX_EN),
    .TX_ER         (TX_ER),
    .cnt_clr       (cnt_clr),
    .tx_byte       (o_b[1]),
    .tx_is_k       (o_k[1]),
    .tx_even       (o_e[1]),
    .transmitting  (o_t[1]),
    .pkt_cnt       (pc1),
    .err_cnt       (ec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_comma[i] = 1'b1;
      m_r1[i]    = 1'b0;
      m_first[i] = 1'b0;
      m_pkt[i]   = 0;
      m_err[i]   = 0;
      e_byte[i]  = 8'hBC;
      e_k[i]     = 1'b1;
      e_even[i]  = 1'b1;
      e_tx[i]    = 1'b0;
    end
    n_pos = 0;
  endtask

  // One code group of instance i, given the GMII inputs sampled this edge.
  task automatic model_step(input int i, input logic en, input logic er,
                            input logic [7:0] d, input logic clr, input bit ev);
    logic [7:0] b;
    bit k, tx, cont, ext_en, err_prop;
    int cmax;
    b        = 8'hBC;
    k        = 1'b1;
    tx       = 1'b0;
    ext_en   = (i == 0);
    err_prop = (i == 0);
    cmax     = (i == 0) ? 65535 : 3;
    case (m_phase[i])
      0: begin
        if (m_comma[i]) begin
          b = (i == 0) ? 8'h50 : 8'hC5;
          k = 1'b0;
          m_comma[i] = 1'b0;
        end else if (en) begin
          b  = 8'hFB;
          tx = 1'b1;
          m_phase[i] = 1;
          if (m_pkt[i] < cmax) m_pkt[i]++;
        end else begin
          m_comma[i] = 1'b1;
        end
      end
      1: begin
        tx = 1'b1;
        if (!en) begin
          b = 8'hFD;
          m_phase[i] = 2;
          m_r1[i]    = 1'b0;
          m_first[i] = 1'b1;
        end else if (er && err_prop) begin
          b = 8'hFE;
          if (m_err[i] < cmax) m_err[i]++;
        end else begin
          b = d;
          k = 1'b0;
        end
      end
      default: begin
        if (!m_r1[i]) begin
          b = 8'hF7;
          cont = m_first[i] ? (er && ext_en) : (er && !en && ext_en);
          m_r1[i]    = !cont;
          m_first[i] = 1'b0;
        end else if (ev) begin
          m_phase[i] = 0;
          m_comma[i] = 1'b1;
        end else begin
          b = 8'hF7;
        end
      end
    endcase
    if (clr) begin
      m_pkt[i] = 0;
      m_err[i] = 0;
    end
    e_byte[i] = b;
    e_k[i]    = k;
    e_even[i] = ev;
    e_tx[i]   = tx;
  endtask

  task automatic compare_all();
    logic [31:0] pc [2];
    logic [31:0] ec [2];
    pc[0] = 32'(pc0);
    pc[1] = 32'(pc1);
    ec[0] = 32'(ec0);
    ec[1] = 32'(ec1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d@%0d byte", i, n_pos), 32'(o_b[i]), 32'(e_byte[i]));
      chk($sformatf("u%0d@%0d is_k", i, n_pos), 32'(o_k[i]), 32'(e_k[i]));
      chk($sformatf("u%0d@%0d even", i, n_pos), 32'(o_e[i]), 32'(e_even[i]));
      chk($sformatf("u%0d@%0d txing", i, n_pos), 32'(o_t[i]), 32'(e_tx[i]));
      chk($sformatf("u%0d@%0d pkt_cnt", i, n_pos), pc[i], 32'(m_pkt[i]));
      chk($sformatf("u%0d@%0d err_cnt", i, n_pos), ec[i], 32'(m_err[i]));
    end
  endtask

  task automatic step(input logic en, input logic er, input logic [7:0] d, input logic clr);
    bit ev;
    TX_EN   = en;
    TX_ER   = er;
    TXD     = d;
    cnt_clr = clr;
    @(posedge clk);
    ev = (((n_pos + 1) % 2) == 0);
    model_step(0, en, er, d, clr, ev);
    model_step(1, en, er, d, clr, ev);
    n_pos++;
    #1;
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d byte", tag, i), 32'(o_b[i]), 32'h0000_00BC);
      chk($sformatf("%s u%0d is_k", tag, i), 32'(o_k[i]), 32'd1);
      chk($sformatf("%s u%0d even", tag, i), 32'(o_e[i]), 32'd1);
      chk($sformatf("%s u%0d txing", tag, i), 32'(o_t[i]), 32'd0);
    end
    chk({tag, " pkt0"}, 32'(pc0), 32'd0);
    chk({tag, " err0"}, 32'(ec0), 32'd0);
    chk({tag, " pkt1"}, 32'(pc1), 32'd0);
  endtask

  // Packet of len TX_EN cycles, then ext cycles of TX_ER-only, then gap idles.
  task automatic send_pkt(input int len, input int er_pct, input int ext,
                          input int gap, input bit clr_on_sop);
    bit c;
    for (int j = 0; j < len; j++) begin
      c = clr_on_sop && (m_phase[1] == 0) && !m_comma[1];
      step(1'b1, 1'($urandom_range(99) < er_pct), 8'($urandom), c);
    end
    for (int j = 0; j < ext; j++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int j = 0; j < gap; j++) step(1'b0, 1'($urandom_range(3) == 0), 8'($urandom), 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    TXD     = 8'h00;
    TX_EN   = 1'b0;
    TX_ER   = 1'b0;
    cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Idle pattern.
    for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 8'h00, 1'b0);

    // Preamble starting when the comma is the last group emitted.
    while (!m_comma[0]) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b1, 1'b0, 8'hD5, 1'b0);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("pkt_after_first", 32'(pc0), 32'd1);

    // Errors inside a packet, extension after it, both /T/ parities.
    send_pkt(6, 40, 3, 6, 1'b0);
    send_pkt(3, 0, 0, 5, 1'b0);
    send_pkt(4, 0, 0, 5, 1'b0);
    send_pkt(2, 0, 1, 5, 1'b0);

    // Randomized traffic, including gaps that overlap the tail.
    for (int p = 0; p < 250; p++) begin
      send_pkt($urandom_range(12, 1), 12, ($urandom_range(3) == 0) ? $urandom_range(4) : 0,
               $urandom_range(6), 1'b0);
      if ($urandom_range(30) == 0) step(1'b0, 1'b0, 8'h00, 1'b1);
    end

    // Saturation of the 2-bit counter, then clear on the SOP cycle.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int p = 0; p < 5; p++) send_pkt(4, 0, 0, 5, 1'b0);
    chk("sat_pkt1", 32'(pc1), 32'd3);
    send_pkt(4, 0, 0, 5, 1'b1);
    chk("clr_on_sop_pkt1", 32'(pc1), 32'd0);

    // Asynchronous reset in the middle of a packet.
    for (int j = 0; j < 5; j++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("midpkt_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    chk("rst_first_grp", 32'(o_b[0]), 32'h0000_0050);
    for (int j = 0; j < 20; j++) step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
